// File: rtl/calc_pkg.sv
// Shared types and key codes for the keypad calculator front-end.
package calc_pkg;

  typedef enum logic [3:0] {
    StEntA  = 4'd0,
    StConvA = 4'd1,
    StWrA   = 4'd2,
    StOpsel = 4'd3,
    StWrOp  = 4'd4,
    StEntB  = 4'd5,
    StConvB = 4'd6,
    StWrB   = 4'd7,
    StRun   = 4'd8,
    StResRd = 4'd9,
    StShow  = 4'd10,
    StErr   = 4'd11
  } state_e;

  localparam logic [4:0] KEY_ENTER = 5'd10;
  localparam logic [4:0] KEY_CLR   = 5'd11;
  localparam logic [4:0] KEY_BS    = 5'd12;
  localparam logic [4:0] KEY_OP0   = 5'd16;

  typedef enum logic [1:0] {
    OpAdd = 2'd0,
    OpSub = 2'd1,
    OpAnd = 2'd2,
    OpOr  = 2'd3
  } op_e;

  function automatic logic is_op_key(input logic [4:0] k);
    return (k >= KEY_OP0) && (k <= KEY_OP0 + 5'd3);
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, most significant digit first, one digit per cycle.
module bcd_to_bin_seq #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           bin
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(DIGITS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DIGITS - 1);

  logic [W-1:0]    shift_q, shift_d;
  logic [31:0]     acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // The first digit is consumed on the start edge so the whole job spans DIGITS edges.
  always_comb begin
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (busy_q) begin
      acc_d   = (acc_q << 3) + (acc_q << 1) + 32'(shift_q[W-1 -: 4]);
      shift_d = shift_q << 4;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == CntLast) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      acc_d   = 32'(bcd[W-1 -: 4]);
      shift_d = bcd << 4;
      cnt_d   = CntW'(1);
      if (DIGITS == 1) begin
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bin  = acc_q;

endmodule

// File: rtl/keypad_calc_ctrl.sv
// Keypad calculator front-end: collects operands and opcode, writes them to the CPU's
// mailbox, runs the CPU with a timeout and shows the result read back.
module keypad_calc_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter logic [31:0] ADDR_OP1    = 32'd220,
  parameter logic [31:0] ADDR_OP2    = 32'd240,
  parameter logic [31:0] ADDR_OPSEL  = 32'd260,
  parameter logic [31:0] ADDR_RESULT = 32'd280,
  parameter logic [31:0] ADDR_IDLE   = 32'd320,
  parameter logic [31:0] DONE_WORD   = 32'hFFFF_FFFF,
  parameter int unsigned TIMEOUT     = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [4:0]          key_code,
  input  logic [31:0]         instruction,
  input  logic [31:0]         data_in,
  output logic [31:0]         address,
  output logic [31:0]         data_out,
  output logic                fpga_en,
  output logic                fpga_write,
  output logic                cpu_en,
  output logic [4*DIGITS-1:0] disp,
  output logic [3:0]          state_o,
  output logic                error
);

  localparam int unsigned W = 4 * DIGITS;
  localparam logic [31:0] RunLast = 32'(TIMEOUT - 1);

  state_e       state_q, state_d;
  logic [W-1:0] fa_q, fa_d, fb_q, fb_d;
  logic [3:0]   na_q, na_d, nb_q, nb_d;
  op_e          op_q, op_d;
  logic         op_vld_q, op_vld_d;
  logic [31:0]  run_cnt_q, run_cnt_d;
  logic [31:0]  result_q, result_d;
  logic         done_q;

  logic         key_enter, key_clr, in_entry;
  logic         conv_start, conv_busy, conv_done;
  logic [31:0]  conv_bin;
  logic [W-1:0] conv_bcd;
  logic [W-1:0] ent_f;
  logic [3:0]   ent_n;

  assign key_enter  = key_valid && (key_code == KEY_ENTER);
  assign key_clr    = key_valid && (key_code == KEY_CLR);
  assign in_entry   = (state_q == StEntA) || (state_q == StEntB);
  assign conv_bcd   = (state_q == StEntB) ? fb_q : fa_q;
  assign conv_start = key_enter && in_entry && !conv_busy;

  bcd_to_bin_seq #(
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bcd   (conv_bcd),
    .busy  (conv_busy),
    .done  (conv_done),
    .bin   (conv_bin)
  );

  // Edit of whichever operand field is active; committed only on a key strobe.
  always_comb begin
    ent_f = conv_bcd;
    ent_n = (state_q == StEntB) ? nb_q : na_q;
    if (key_code <= 5'd9) begin
      if (ent_n < 4'(DIGITS)) begin
        ent_f = (ent_f << 4) | W'(key_code[3:0]);
        ent_n = ent_n + 4'd1;
      end
    end else if (key_code == KEY_BS) begin
      if (ent_n != 4'd0) begin
        ent_f = ent_f >> 4;
        ent_n = ent_n - 4'd1;
      end
    end else if (key_code == KEY_CLR) begin
      ent_f = '0;
      ent_n = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    fa_d      = fa_q;
    na_d      = na_q;
    fb_d      = fb_q;
    nb_d      = nb_q;
    op_d      = op_q;
    op_vld_d  = op_vld_q;
    run_cnt_d = run_cnt_q;
    result_d  = result_q;
    case (state_q)
      StEntA: begin
        if (conv_start) begin
          state_d = StConvA;
        end else if (key_valid) begin
          fa_d = ent_f;
          na_d = ent_n;
        end
      end
      StConvA: if (conv_done) state_d = StWrA;
      StWrA:   state_d = StOpsel;
      StOpsel: begin
        if (key_valid) begin
          if (is_op_key(key_code)) begin
            op_d     = op_e'(2'(key_code - KEY_OP0));
            op_vld_d = 1'b1;
          end else if (key_clr) begin
            op_d     = OpAdd;
            op_vld_d = 1'b0;
          end else if (key_enter && op_vld_q) begin
            state_d = StWrOp;
          end
        end
      end
      StWrOp:  state_d = StEntB;
      StEntB: begin
        if (conv_start) begin
          state_d = StConvB;
        end else if (key_valid) begin
          fb_d = ent_f;
          nb_d = ent_n;
        end
      end
      StConvB: if (conv_done) state_d = StWrB;
      StWrB: begin
        state_d   = StRun;
        run_cnt_d = '0;
      end
      StRun: begin
        // Completion takes priority over a timeout landing on the same cycle.
        if (done_q) begin
          state_d = StResRd;
        end else if (run_cnt_q == RunLast) begin
          state_d = StErr;
        end else begin
          run_cnt_d = run_cnt_q + 32'd1;
        end
      end
      StResRd: begin
        result_d = data_in;
        state_d  = StShow;
      end
      StShow, StErr: begin
        if (key_enter || key_clr) begin
          state_d  = StEntA;
          fa_d     = '0;
          na_d     = '0;
          fb_d     = '0;
          nb_d     = '0;
          op_d     = OpAdd;
          op_vld_d = 1'b0;
        end
      end
      default: state_d = StEntA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StEntA;
      fa_q      <= '0;
      na_q      <= '0;
      fb_q      <= '0;
      nb_q      <= '0;
      op_q      <= OpAdd;
      op_vld_q  <= 1'b0;
      run_cnt_q <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fa_q      <= fa_d;
      na_q      <= na_d;
      fb_q      <= fb_d;
      nb_q      <= nb_d;
      op_q      <= op_d;
      op_vld_q  <= op_vld_d;
      run_cnt_q <= run_cnt_d;
      result_q  <= result_d;
      done_q    <= (state_q == StRun) && (instruction == DONE_WORD);
    end
  end

  always_comb begin
    address    = ADDR_IDLE;
    data_out   = '0;
    fpga_en    = 1'b0;
    fpga_write = 1'b0;
    cpu_en     = 1'b0;
    error      = 1'b0;
    disp       = fa_q;
    case (state_q)
      StEntA, StConvA: disp = fa_q;
      StWrA: begin
        disp       = fa_q;
        address    = ADDR_OP1;
        data_out   = conv_bin;
        fpga_en    = 1'b1;
        fpga_write = 1'b1;
      end
      StOpsel: disp = W'(op_q);
      StWrOp: begin
        disp       = W'(op_q);
        address    = ADDR_OPSEL;
        data_out   = 32'(op_q);
        fpga_en    = 1'b1;
        fpga_write = 1'b1;
      end
      StEntB, StConvB: disp = fb_q;
      StWrB: begin
        disp       = fb_q;
        address    = ADDR_OP2;
        data_out   = conv_bin;
        fpga_en    = 1'b1;
        fpga_write = 1'b1;
      end
      StRun: begin
        disp   = fb_q;
        cpu_en = 1'b1;
      end
      StResRd: begin
        disp    = fb_q;
        address = ADDR_RESULT;
        fpga_en = 1'b1;
      end
      StShow: disp = W'(result_q);
      StErr: begin
        disp  = {DIGITS{4'hE}};
        error = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_keypad_calc_ctrl.sv
// Scoreboard bench: stimulus queues expected bus transfers and end results, a monitor checks them.
module tb_keypad_calc_ctrl;
  import calc_pkg::*;

  localparam int unsigned DIGITS = 4;
  localparam int TIMEOUT = 16;
  localparam logic [31:0] DONE = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, key_valid;
  logic [4:0]  key_code;
  logic [31:0] instruction, data_in, address, data_out;
  logic        fpga_en, fpga_write, cpu_en, error;
  logic [15:0] disp;
  logic [3:0]  state_o;

  always #5 clk = ~clk;

  keypad_calc_ctrl #(
    .DIGITS  (DIGITS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .instruction (instruction),
    .data_in     (data_in),
    .address     (address),
    .data_out    (data_out),
    .fpga_en     (fpga_en),
    .fpga_write  (fpga_write),
    .cpu_en      (cpu_en),
    .disp        (disp),
    .state_o     (state_o),
    .error       (error)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          wr;
    longint      cyc;
  } bus_t;

  typedef struct {
    bit          err;
    logic [15:0] disp;
    int          run_len;
  } end_t;

  bus_t   exp_bus[$];
  end_t   exp_end[$];
  int     digs[$];
  int     total = 0;
  int     bad = 0;
  longint cyc = 0;
  int     run_len = 0;
  logic [3:0] prev_st = 4'd0;
  bus_t   mb;
  end_t   me;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every bus transfer and every arrival in SHOW/ERR consumes one expectation.
  always @(negedge clk) begin
    if (rst) begin
      prev_st = 4'd0;
      run_len = 0;
    end else begin
      if (fpga_en || fpga_write) begin
        if (exp_bus.size() == 0) begin
          total++;
          bad++;
          $display("FAIL bus_extra: got transfer at address %0d expected none", address);
        end else begin
          mb = exp_bus.pop_front();
          chk("bus_addr", address, mb.addr);
          chk("bus_write", fpga_write, mb.wr);
          if (mb.wr) chk("bus_data", data_out, mb.data);
          if (mb.cyc >= 0) chk("bus_cycle", cyc, mb.cyc);
        end
      end
      if (state_o == StRun) begin
        run_len = (prev_st == StRun) ? run_len + 1 : 1;
        chk("run_cpu_en", cpu_en, 1);
        chk("run_fpga_en", fpga_en, 0);
      end
      if (state_o != prev_st && (state_o == StShow || state_o == StErr)) begin
        if (exp_end.size() == 0) begin
          total++;
          bad++;
          $display("FAIL end_extra: got state %0d expected none", state_o);
        end else begin
          me = exp_end.pop_front();
          chk("end_error", error, me.err);
          chk("end_disp", disp, me.disp);
          chk("run_len", run_len, me.run_len);
        end
      end
      prev_st = state_o;
    end
  end

  function automatic logic [15:0] bcd_of();
    logic [15:0] r = '0;
    foreach (digs[i]) r = (r << 4) | 16'(digs[i]);
    return r;
  endfunction

  function automatic logic [31:0] val_of();
    logic [31:0] v = '0;
    foreach (digs[i]) v = v * 10 + 32'(digs[i]);
    return v;
  endfunction

  function automatic logic [4:0] rand_key();
    int r = int'($urandom_range(0, 19));
    if (r <= 13) return 5'(r % 10);
    if (r == 19) return 5'd9;
    if (r <= 15) return KEY_BS;
    if (r == 16) return KEY_CLR;
    return 5'(16 + $urandom_range(0, 3));
  endfunction

  task automatic press(input logic [4:0] k, input bit push, input logic [31:0] a,
                       input logic [31:0] d, input int dly);
    bus_t b;
    @(negedge clk);
    if (push) begin
      b.addr = a;
      b.data = d;
      b.wr   = 1'b1;
      b.cyc  = cyc + 1 + dly;
      exp_bus.push_back(b);
    end
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 5'd0;
  endtask

  task automatic wait_state(input state_e tgt, input int budget);
    int n = 0;
    while (state_o != tgt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("reach_state", state_o, tgt);
  endtask

  // Entry key with the digit-list model of the field.
  task automatic mkey(input logic [4:0] k);
    if (k <= 5'd9) begin
      if (digs.size() < int'(DIGITS)) digs.push_back(int'(k));
    end else if (k == KEY_BS) begin
      if (digs.size() > 0) void'(digs.pop_back());
    end else if (k == KEY_CLR) begin
      digs.delete();
    end
    press(k, 0, 0, 0, 0);
    chk("entry_disp", disp, bcd_of());
  endtask

  task automatic enter_op(input bit is_b, output logic [31:0] v);
    v = val_of();
    press(KEY_ENTER, 1, is_b ? 32'd240 : 32'd220, v, 4);
    digs.delete();
    if ($urandom_range(0, 1) == 1) press(5'd5, 0, 0, 0, 0);
    wait_state(is_b ? StRun : StOpsel, 20);
  endtask

  task automatic do_op(input logic [4:0] opk);
    chk("opsel_disp0", disp, 0);
    press(KEY_ENTER, 0, 0, 0, 0);
    chk("opsel_hold", state_o, StOpsel);
    press(opk, 0, 0, 0, 0);
    chk("op_disp", disp, 16'(opk - 5'd16));
    if ($urandom_range(0, 1) == 1) begin
      press(KEY_CLR, 0, 0, 0, 0);
      chk("op_clr_disp", disp, 0);
      press(KEY_ENTER, 0, 0, 0, 0);
      chk("op_clr_hold", state_o, StOpsel);
      press(opk, 0, 0, 0, 0);
    end
    press(KEY_ENTER, 1, 32'd260, 32'(opk - 5'd16), 0);
    wait_state(StEntB, 5);
    chk("entb_disp0", disp, 0);
  endtask

  // Called on the first RUN cycle; d<0 means the CPU never reports done.
  task automatic run_phase(input int d, input logic [4:0] opk, input logic [31:0] a,
                           input logic [31:0] b, input bit via_clr);
    logic [31:0] res;
    bus_t bb;
    end_t ee;
    int n;
    case (opk)
      5'd16:   res = a + b;
      5'd17:   res = a - b;
      5'd18:   res = a & b;
      default: res = a | b;
    endcase
    data_in = res;
    if (d >= 0 && d + 2 <= TIMEOUT) begin
      bb.addr = 32'd280;
      bb.data = '0;
      bb.wr   = 1'b0;
      bb.cyc  = -1;
      exp_bus.push_back(bb);
      ee.err = 1'b0;
      ee.disp = res[15:0];
      ee.run_len = d + 2;
    end else begin
      ee.err = 1'b1;
      ee.disp = 16'hEEEE;
      ee.run_len = TIMEOUT;
    end
    exp_end.push_back(ee);
    if (d >= 0) begin
      repeat (d) @(negedge clk);
      instruction = DONE;
    end
    n = 0;
    while (!(state_o == StShow || state_o == StErr) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("end_reached", (state_o == StShow || state_o == StErr), 1);
    instruction = $urandom() & 32'h7FFF_FFFF;
    press(via_clr ? KEY_CLR : KEY_ENTER, 0, 0, 0, 0);
    wait_state(StEntA, 3);
    chk("restart_disp", disp, 0);
    chk("restart_err", error, 0);
  endtask

  task automatic flow(input int d, input bit via_clr);
    logic [31:0] va, vb;
    logic [4:0]  opk;
    repeat ($urandom_range(0, 7)) mkey(rand_key());
    enter_op(0, va);
    opk = 5'(16 + $urandom_range(0, 3));
    do_op(opk);
    repeat ($urandom_range(0, 7)) mkey(rand_key());
    enter_op(1, vb);
    run_phase(d, opk, va, vb, via_clr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] va, vb;
    rst = 1'b1;
    key_valid = 1'b0;
    key_code = 5'd0;
    instruction = 32'd0;
    data_in = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", state_o, StEntA);
    chk("reset_disp", disp, 0);
    chk("reset_cpu_en", cpu_en, 0);
    chk("reset_error", error, 0);
    chk("reset_fpga_en", fpga_en, 0);
    chk("reset_addr", address, 32'd320);

    // Field limits, backspace and clear, then 12 ADD 7 with result 19.
    mkey(5'd1); mkey(5'd2); mkey(5'd3); mkey(5'd4); mkey(5'd5);
    chk("five_dropped", disp, 16'h1234);
    mkey(KEY_BS);
    chk("backspace", disp, 16'h0123);
    mkey(KEY_CLR);
    chk("clear", disp, 16'h0000);
    mkey(5'd1); mkey(5'd2);
    enter_op(0, va);
    do_op(5'd16);
    mkey(5'd7);
    enter_op(1, vb);
    run_phase(3, 5'd16, va, vb, 1'b0);

    // 123 write timing, then a CPU that never finishes.
    mkey(5'd1); mkey(5'd2); mkey(5'd3);
    enter_op(0, va);
    do_op(5'd19);
    mkey(5'd4);
    enter_op(1, vb);
    run_phase(-1, 5'd19, va, vb, 1'b0);

    // Done and timeout on the same cycle.
    flow(TIMEOUT - 2, 1'b1);

    for (int i = 0; i < 8; i++) flow(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));

    // Reset while the CPU is running.
    mkey(5'd9); mkey(5'd8);
    enter_op(0, va);
    do_op(5'd17);
    mkey(5'd3);
    enter_op(1, vb);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_state", state_o, StEntA);
    chk("midrun_cpu_en", cpu_en, 0);
    chk("midrun_disp", disp, 0);
    chk("midrun_error", error, 0);
    chk("midrun_addr", address, 32'd320);
    enter_op(0, va);
    do_op(5'd16);
    enter_op(1, vb);
    run_phase(1, 5'd16, va, vb, 1'b0);

    repeat (3) @(negedge clk);
    chk("bus_queue_empty", exp_bus.size(), 0);
    chk("end_queue_empty", exp_end.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_calc_ctrl.md
# keypad_calc_ctrl

Parametrised keypad-to-CPU calculator front-end for the FPGA board. It collects two BCD operands and an operation select from the key synchroniser and converts each operand to binary with a sequential converter. It writes operands and opcode to fixed memory-mapped addresses, hands the bus to the CPU, and waits for the done instruction word with a timeout. It then reads back the result and presents it on a display bus.

## Interface
- DIGITS, 4: BCD digits per operand; legal range 1..9, so that operands fit 32 bits.
- ADDR_OP1, 32'd220: operand A write address.
- ADDR_OP2, 32'd240: operand B write address.
- ADDR_OPSEL, 32'd260: opcode write address.
- ADDR_RESULT, 32'd280: result read address.
- ADDR_IDLE, 32'd320: address driven when no transfer is active.
- DONE_WORD, 32'hFFFF_FFFF: instruction value that signals CPU completion.
- TIMEOUT, 1_000_000: maximum cycles spent in RUN; minimum 2.
- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous and active-high.
- key_valid  in  1  one-cycle strobe from the key synchroniser.
- key_code  in  5  key code: 0–9 digit, 10 enter, 11 clear, 12 backspace, 16–19 op (ADD, SUB, AND, OR).
- instruction  in  32  CPU instruction bus, compared against DONE_WORD.
- data_in  in  32  memory read data.
- address  out  32  bus address.
- data_out  out  32  bus write data.
- fpga_en  out  1  FPGA owns the bus.
- fpga_write  out  1  write strobe.
- cpu_en  out  1  CPU run enable.
- disp  out  4*DIGITS  display nibbles, least significant nibble = rightmost digit.
- state_o  out  4  current state, for debug LEDs.
- error  out  1  high while in ERR.

## Operation
- States: ENT_A, CONV_A, WR_A, OPSEL, WR_OP, ENT_B, CONV_B, WR_B, RUN, RES_RD, SHOW, ERR.
- Entry states (ENT_A, ENT_B):
  - Digit key: shifts into the BCD field at the right if fewer than DIGITS digits are held; otherwise ignored.
  - Backspace: shifts the field right and decrements the count; no effect when empty.
  - Clear: zeroes the field and the count.
  - Enter: starts conversion; an empty field converts to 0.
  - Op keys: ignored.
- CONV_x: the converter processes the most significant digit first, acc = acc*10 + digit, taking exactly DIGITS cycles. Its done pulse moves the FSM to WR_x.
- WR_x, WR_OP: one cycle each.
  - address = ADDR_OP1, ADDR_OP2 or ADDR_OPSEL respectively.
  - data_out = binary operand, or the opcode (key_code−16) zero-extended.
  - fpga_en = 1, fpga_write = 1.
- OPSEL:
  - Op key latches the opcode.
  - Enter with an opcode latched → WR_OP. Enter with none latched is ignored.
  - Clear unlatches the opcode.
- RUN:
  - cpu_en = 1, fpga_en = 0, fpga_write = 0.
  - done_q is registered as (instruction == DONE_WORD).
  - done_q = 1 → RES_RD.
  - When the cycle counter reaches TIMEOUT−1 with done_q = 0 → ERR.
  - If both conditions occur in the same cycle, done wins.
- RES_RD: one cycle; address = ADDR_RESULT, fpga_en = 1, fpga_write = 0. data_in is captured into the result register on this edge.
- SHOW: disp = result[4*DIGITS-1:0] in hex. Enter or clear → ENT_A; both operand fields and the opcode are zeroed.
- ERR: disp = all nibbles 4'hE, error = 1. Enter or clear → ENT_A, with the same zeroing as SHOW.
- disp in other states:
  - ENT_A, CONV_A, WR_A: field A.
  - ENT_B, CONV_B, WR_B: field B.
  - OPSEL, WR_OP: opcode.
  - RUN, RES_RD: last value shown.
- Keys arriving in CONV, WR, RUN and RES_RD states are dropped, not queued.
- Defaults in all states not listed above: address = ADDR_IDLE, data_out = 0, fpga_en = 0, fpga_write = 0, cpu_en = 0.

## Timing
- All registers update on rising clk. The state updates one cycle after key_valid.
- Reset (including mid-RUN or mid-CONV) gives, on the next edge:
  - state = ENT_A; fields, opcode, result and counters = 0.
  - All outputs at defaults: cpu_en = 0, disp = 0, error = 0, state_o = ENT_A.
- Latencies:
  - Enter accepted at edge t → CONV for cycles t+1 … t+DIGITS → WR at t+DIGITS+1.
  - instruction = DONE_WORD sampled at edge t → done_q high after t → RES_RD at t+1 → SHOW at t+2.
- The RUN counter clears on entry to RUN.
- The converter ignores start while busy.

## Structure
- Package calc_pkg holds:
  - the state enum (4-bit);
  - key code constants KEY_ENTER, KEY_CLR and KEY_BS;
  - op base KEY_OP0 = 16 and the op enum.
- Sub-module bcd_to_bin_seq (parameter DIGITS):
  - inputs: clk, rst, start, bcd[4*DIGITS-1:0];
  - outputs: busy, done (one-cycle pulse), bin[31:0].

## Test plan
- DIGITS=4; keys 1, 2, 3, enter → after 4 CONV cycles, one cycle with address=220, data_out=123, fpga_write=1.
- Keys 1, 2, 3, 4, 5 → disp=16'h1234, digit 5 dropped. Then backspace → disp=16'h0123. Then clear → disp=0.
- Full flow 12, enter, ADD(16), enter, 7, enter:
  - writes 220/12, 260/0, 240/7;
  - cpu_en held until instruction=FFFF_FFFF;
  - then a read of 280 with data_in=19 → disp=16'h0013 in SHOW.
- TIMEOUT=16, DONE_WORD never driven → ERR exactly 16 cycles after RUN entry, error=1, disp=16'hEEEE. Enter → ENT_A.
- rst asserted for one cycle mid-RUN → next edge cpu_en=0, state_o=ENT_A, all fields 0.
- Done and timeout in the same cycle → RES_RD, error stays 0.
